mmio_uart_tx: RTL and testbench

//  Memory-mapped console output sitting directly downstream of the pipelined cpu store port.

---
 rtl/cpu_io_pkg.sv | 15 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 141 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the cpu-side memory-mapped I/O blocks.
// Holds the UART serializer state encoding and the default transmit register address.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam logic [31:0] DEFAULT_TX_ADDR = 32'hFFFF_0000;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with first-word-fall-through read data and a registered occupancy count.
// A push into a full FIFO is only taken when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: cpu byte stores to TX_ADDR are queued and sent as 8N1 frames.
// The cpu cannot be stalled, so stores that hit a full FIFO are dropped and latch a sticky overflow flag.
module mmio_uart_tx
  import cpu_io_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_write,
  input  logic [7:0]                    data,
  input  logic [31:0]                   data_address,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(UART_DATA_BITS - 1);

  uart_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;

  logic          push_req;
  logic          pop;
  logic          bit_last;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push_req = data_write && (data_address == TX_ADDR);
  assign bit_last = (timer_q == TIMER_LAST);

  always_comb begin
    overflow_d = overflow_q | (push_req & fifo_full & ~pop);
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d   = state_q;
    timer_d   = bit_last ? '0 : timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-position model predicts tx/busy/fifo_count/overflow every cycle,
// and directed scenarios add literal checks at hand-computed points.
module tb_mmio_uart_tx;

  localparam logic [31:0] TX    = 32'hFFFF_0000;
  localparam int          DEPTH = 4;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk;
  logic        reset;
  logic        data_write;
  logic [7:0]  data;
  logic [31:0] data_address;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_tx #(
    .TX_ADDR      (TX),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data         (data),
    .data_address (data_address),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending bytes plus the position inside the frame being sent.
  byte unsigned q[$];
  bit           m_active;
  int           m_pos;
  logic [9:0]   m_frame;
  bit           m_ovf;
  bit           m_valid = 0;
  bit           m_pop;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
      m_valid  = 1;
    end else begin
      m_pop = (!m_active || m_pos == FRAME - 1) && q.size() > 0;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 0;
      end
      if (m_pop) begin
        m_frame  = {1'b1, q.pop_front(), 1'b0};
        m_active = 1;
        m_pos    = 0;
      end
      if (data_write && data_address == TX) begin
        if (q.size() < DEPTH) q.push_back(data);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tx", {31'd0, tx}, {31'd0, m_active ? m_frame[m_pos / CPB] : 1'b1});
      chk("model_busy", {31'd0, busy}, {31'd0, m_active || q.size() != 0});
      chk("model_count", {29'd0, fifo_count}, q.size());
      chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    data_write   = 1'b1;
    data_address = a;
    data         = d;
    step(1);
    data_write   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      step(1);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  logic [9:0] pat55;

  initial begin
    reset        = 1'b1;
    data_write   = 1'b0;
    data         = 8'h00;
    data_address = 32'h0;
    step(2);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {29'd0, fifo_count}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    step(1);

    // 1: single 0x55 frame, sampled once per bit
    pat55 = 10'b1010101010;
    store(TX, 8'h55);
    chk("t1_not_yet", {31'd0, tx}, 32'd1);
    chk("t1_count1", {29'd0, fifo_count}, 32'd1);
    step(1);
    for (int k = 0; k < 10; k++) begin
      chk("t1_bit", {31'd0, tx}, {31'd0, pat55[k]});
      step(CPB);
    end
    chk("t1_busy_done", {31'd0, busy}, 32'd0);

    // 2: wrong addresses and a non-write are ignored
    store(TX - 32'd1, 8'hA5);
    store(TX + 32'd4, 8'hA5);
    data_address = TX;
    data         = 8'hA5;
    step(1);
    for (int k = 0; k < 3; k++) begin
      chk("t2_tx", {31'd0, tx}, 32'd1);
      chk("t2_count", {29'd0, fifo_count}, 32'd0);
      step(1);
    end

    // 3: two contiguous frames
    store(TX, 8'h01);
    store(TX, 8'h02);
    step(39);
    chk("t3_stop1", {31'd0, tx}, 32'd1);
    step(1);
    chk("t3_start2", {31'd0, tx}, 32'd0);
    step(4);
    chk("t3_b0", {31'd0, tx}, 32'd0);
    step(4);
    chk("t3_b1", {31'd0, tx}, 32'd1);
    wait_idle(100);

    // 4: six back-to-back stores, last one dropped
    for (int k = 0; k < 6; k++) store(TX, 8'h10 + 8'(k));
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_count", {29'd0, fifo_count}, 32'd4);
    wait_idle(5 * FRAME + 20);

    // 5: store on the stop-last-cycle pop edge while full
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) store(TX, 8'h20 + 8'(k));
    step(36);
    chk("t5_full_before", {29'd0, fifo_count}, 32'd4);
    store(TX, 8'h99);
    chk("t5_count", {29'd0, fifo_count}, 32'd4);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_start", {31'd0, tx}, 32'd0);
    wait_idle(6 * FRAME + 20);

    // 6: reset during data bit 3 of 0xFF with two bytes queued
    store(TX, 8'hFF);
    store(TX, 8'h11);
    store(TX, 8'h22);
    step(16);
    chk("t6_pre_tx", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_tx", {31'd0, tx}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    store(TX, 8'h3C);
    step(1);
    chk("t6_new_start", {31'd0, tx}, 32'd0);
    wait_idle(FRAME + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
